// File: rtl/control_fsm.sv
// Multi-cycle RISC-V control unit: five-state sequencer (IF/ID/EX/MEM/WB) with
// combinational decode, registered PC strobes, retired-instruction counter and sticky illegal flag.
module control_fsm (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        Zero,
   output logic        PCSrc,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic [3:0]  ALUCtrl,
   output logic        loadPC,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        illegal,
   output logic [31:0] instret
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_XOR = 4'b1101;

   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

   state_t      state_q, state_d;
   logic        pcsrc_q, pcsrc_d;
   logic        loadpc_q, loadpc_d;
   logic        zero_q, zero_d;
   logic        illegal_q, illegal_d;
   logic [31:0] instret_q, instret_d;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        alt;
   logic        op_illegal;
   logic        writes_rf;
   logic        is_lw, is_sw, is_beq;
   logic        unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign alt         = instr[30];
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

   function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic a);
      case (f3)
         3'b000:  alu_from_funct = a ? ALU_SUB : ALU_ADD;
         3'b001:  alu_from_funct = ALU_SLL;
         3'b010:  alu_from_funct = ALU_SLT;
         3'b100:  alu_from_funct = ALU_XOR;
         3'b101:  alu_from_funct = a ? ALU_SRA : ALU_SRL;
         3'b110:  alu_from_funct = ALU_OR;
         3'b111:  alu_from_funct = ALU_AND;
         default: alu_from_funct = ALU_ADD;
      endcase
   endfunction

   always_comb begin
      ALUCtrl    = ALU_ADD;
      ALUSrc     = 1'b0;
      MemToReg   = 1'b0;
      op_illegal = 1'b0;
      writes_rf  = 1'b0;
      is_lw      = 1'b0;
      is_sw      = 1'b0;
      is_beq     = 1'b0;
      case (opcode)
         OP_R: begin
            ALUCtrl   = alu_from_funct(funct3, alt);
            writes_rf = 1'b1;
         end
         OP_I: begin
            ALUSrc = 1'b1;
            if (funct3 == 3'b011) begin
               op_illegal = 1'b1;
            end else begin
               // instr[30] only distinguishes SRAI from SRLI
               ALUCtrl   = alu_from_funct(funct3, alt & (funct3 == 3'b101));
               writes_rf = 1'b1;
            end
         end
         OP_LW: begin
            ALUSrc    = 1'b1;
            MemToReg  = 1'b1;
            writes_rf = 1'b1;
            is_lw     = 1'b1;
         end
         OP_SW: begin
            ALUSrc = 1'b1;
            is_sw  = 1'b1;
         end
         OP_BEQ: begin
            ALUCtrl = ALU_SUB;
            is_beq  = 1'b1;
         end
         default: op_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pcsrc_d   = pcsrc_q;
      loadpc_d  = loadpc_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      instret_d = instret_q;
      RegWrite  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      case (state_q)
         S_IF: begin
            state_d  = S_ID;
            loadpc_d = 1'b0;
         end
         S_ID: state_d = S_EX;
         S_EX: begin
            state_d = S_MEM;
            zero_d  = Zero;
         end
         S_MEM: begin
            state_d  = S_WB;
            MemRead  = is_lw & ~rst;
            MemWrite = is_sw & ~rst;
         end
         S_WB: begin
            // strobes are gated by rst so a write on the reset edge never commits
            state_d   = S_IF;
            RegWrite  = writes_rf & ~rst;
            pcsrc_d   = is_beq & zero_q;
            loadpc_d  = 1'b1;
            instret_d = instret_q + 32'd1;
            illegal_d = illegal_q | op_illegal;
         end
         default: state_d = S_IF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IF;
         pcsrc_q   <= 1'b0;
         loadpc_q  <= 1'b0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         pcsrc_q   <= pcsrc_d;
         loadpc_q  <= loadpc_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
         instret_q <= instret_d;
      end
   end

   assign PCSrc   = pcsrc_q;
   assign loadPC  = loadpc_q;
   assign illegal = illegal_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: cycle-count reference model checked every negedge,
// plus directed instruction sequences with hand-computed expectations.
module tb_control_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'h002081B3;
   logic        Zero = 1'b0;
   logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal;
   logic [3:0]  ALUCtrl;
   logic [31:0] instret;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   int unsigned m_cyc = 0;
   logic        m_pcsrc = 1'b0, m_zero = 1'b0, m_illegal = 1'b0;
   logic [31:0] m_instret = '0;

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SUB   = 32'h40208133;
   localparam logic [31:0] I_SRA   = 32'h4020D133;
   localparam logic [31:0] I_SRAI  = 32'h4020D113;
   localparam logic [31:0] I_SLTIU = 32'h0020B113;
   localparam logic [31:0] I_LW    = 32'h0040A183;
   localparam logic [31:0] I_SW    = 32'h0020A223;
   localparam logic [31:0] I_BEQ   = 32'h00208463;

   control_fsm dut (
      .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
      .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
      .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
      .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Decode reference: R-type table indexed by {instr[30], funct3}
   function automatic void m_dec(input logic [31:0] w, output logic [3:0] alu,
                                 output logic src, output logic m2r, output logic wr,
                                 output logic ill, output logic lw, output logic sw,
                                 output logic beq);
      logic [3:0] rtab [16];
      logic [6:0] op;
      logic [2:0] f3;
      rtab = '{4'h2, 4'h9, 4'h7, 4'h2, 4'hD, 4'h8, 4'h1, 4'h0,
               4'h6, 4'h9, 4'h7, 4'h2, 4'hD, 4'hA, 4'h1, 4'h0};
      op = w[6:0];
      f3 = w[14:12];
      alu = 4'h2; src = 1'b0; m2r = 1'b0; wr = 1'b0; ill = 1'b0;
      lw = (op == 7'b0000011);
      sw = (op == 7'b0100011);
      beq = (op == 7'b1100011);
      if (op == 7'b0110011) begin
         alu = rtab[{w[30], f3}];
         wr  = 1'b1;
      end else if (op == 7'b0010011) begin
         src = 1'b1;
         if (f3 == 3'b011) ill = 1'b1;
         else begin
            alu = (f3 == 3'b101) ? rtab[{w[30], f3}] : rtab[{1'b0, f3}];
            wr  = 1'b1;
         end
      end else if (lw) begin
         src = 1'b1; m2r = 1'b1; wr = 1'b1;
      end else if (sw) begin
         src = 1'b1;
      end else if (beq) begin
         alu = 4'h6;
      end else begin
         ill = 1'b1;
      end
   endfunction

   // Model: instructions occupy 5-cycle slots counted from reset release
   initial forever begin
      logic [3:0] a; logic s, m, wr, il, lw, sw, bq;
      @(posedge clk);
      if (rst) begin
         m_cyc = 0; m_pcsrc = 1'b0; m_zero = 1'b0; m_illegal = 1'b0; m_instret = '0;
      end else begin
         m_dec(instr, a, s, m, wr, il, lw, sw, bq);
         if (m_cyc % 5 == 2) m_zero = Zero;
         if (m_cyc % 5 == 4) begin
            m_pcsrc   = bq & m_zero;
            m_instret = m_instret + 32'd1;
            m_illegal = m_illegal | il;
         end
         m_cyc++;
      end
   end

   initial forever begin
      logic [3:0] a; logic s, m, wr, il, lw, sw, bq;
      int unsigned ph;
      @(negedge clk);
      if (chk_en) begin
         m_dec(instr, a, s, m, wr, il, lw, sw, bq);
         ph = m_cyc % 5;
         check("PCSrc",    PCSrc,    m_pcsrc);
         check("ALUSrc",   ALUSrc,   s);
         check("MemToReg", MemToReg, m);
         check("ALUCtrl",  ALUCtrl,  a);
         check("RegWrite", RegWrite, (ph == 4) && wr && !rst);
         check("MemRead",  MemRead,  (ph == 3) && lw && !rst);
         check("MemWrite", MemWrite, (ph == 3) && sw && !rst);
         check("loadPC",   loadPC,   (m_cyc >= 5) && (ph == 0));
         check("illegal",  illegal,  m_illegal);
         check("instret",  instret,  m_instret);
      end
   end

   // Runs one instruction from IF+2 to the next IF+2, recording per-cycle strobes
   task automatic run_instr(input logic [31:0] w, input logic zex, input logic zmem,
                            output logic [4:0] rw, output logic [4:0] mr,
                            output logic [4:0] mw, output logic [3:0] alu,
                            output logic src, output logic m2r);
      instr = w;
      Zero  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) Zero = zex;
         if (i == 3) Zero = zmem;
         #2;
         rw[i] = RegWrite; mr[i] = MemRead; mw[i] = MemWrite;
         if (i == 2) begin alu = ALUCtrl; src = ALUSrc; m2r = MemToReg; end
         @(posedge clk); #2;
      end
      Zero = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] rw, mr, mw;
      logic [3:0] alu;
      logic       src, m2r;

      @(posedge clk); #2;
      chk_en = 1'b1;
      check("rst_loadPC", loadPC, 1'b0);
      check("rst_instret", instret, 32'd0);
      repeat (2) begin @(posedge clk); #2; end
      rst = 1'b0;
      #2;
      check("first_if_loadPC", loadPC, 1'b0);
      check("add_alu_comb", ALUCtrl, 4'b0010);
      check("add_alusrc", ALUSrc, 1'b0);

      run_instr(I_ADD, 1'b0, 1'b0, rw, mr, mw, alu, src, m2r);
      check("add_regwrite_wb_only", rw, 5'b10000);
      #2;
      check("add_loadPC", loadPC, 1'b1);
      check("add_pcsrc", PCSrc, 1'b0);
      check("add_instret", instret, 32'd1);

      run_instr(I_SUB, 1'b0, 1'b0, rw, mr, mw, alu, src, m2r);
      check("sub_alu", alu, 4'b0110);
      run_instr(I_SRA, 1'b0, 1'b0, rw, mr, mw, alu, src, m2r);
      check("sra_alu", alu, 4'b1010);
      check("sra_src", src, 1'b0);
      run_instr(I_SRAI, 1'b0, 1'b0, rw, mr, mw, alu, src, m2r);
      check("srai_alu", alu, 4'b1010);
      check("srai_src", src, 1'b1);
      check("srai_regwrite", rw, 5'b10000);
      check("srai_not_illegal", illegal, 1'b0);
      run_instr(I_SLTIU, 1'b0, 1'b0, rw, mr, mw, alu, src, m2r);
      check("sltiu_regwrite", rw, 5'b00000);
      #2;
      check("sltiu_illegal", illegal, 1'b1);
      check("sltiu_instret", instret, 32'd5);

      run_instr(I_LW, 1'b0, 1'b0, rw, mr, mw, alu, src, m2r);
      check("lw_memread", mr, 5'b01000);
      check("lw_memwrite", mw, 5'b00000);
      check("lw_regwrite", rw, 5'b10000);
      check("lw_alu", alu, 4'b0010);
      check("lw_src", src, 1'b1);
      check("lw_m2r", m2r, 1'b1);
      run_instr(I_SW, 1'b0, 1'b0, rw, mr, mw, alu, src, m2r);
      check("sw_memwrite", mw, 5'b01000);
      check("sw_memread", mr, 5'b00000);
      check("sw_regwrite", rw, 5'b00000);

      run_instr(I_BEQ, 1'b1, 1'b0, rw, mr, mw, alu, src, m2r);
      check("beq_taken_alu", alu, 4'b0110);
      #2;
      check("beq_taken_pcsrc", PCSrc, 1'b1);
      check("beq_taken_loadPC", loadPC, 1'b1);
      run_instr(I_BEQ, 1'b0, 1'b1, rw, mr, mw, alu, src, m2r);
      check("beq_nt_alu", alu, 4'b0110);
      #2;
      check("beq_nt_pcsrc", PCSrc, 1'b0);
      check("beq_nt_instret", instret, 32'd9);

      m_instret = 32'hFFFFFFFF;
      force dut.instret_q = 32'hFFFFFFFF;
      #1;
      release dut.instret_q;
      run_instr(I_ADD, 1'b0, 1'b0, rw, mr, mw, alu, src, m2r);
      #2;
      check("wrap_instret", instret, 32'd0);
      check("wrap_illegal", illegal, 1'b1);

      instr = I_ADD;
      repeat (4) begin @(posedge clk); #2; end
      rst = 1'b1;
      #2;
      check("rst_wb_regwrite", RegWrite, 1'b0);
      @(posedge clk); #2;
      check("rst_wb_loadPC", loadPC, 1'b0);
      check("rst_wb_instret", instret, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      #2;
      check("rst_wb_first_if_loadPC", loadPC, 1'b0);

      instr = I_SW;
      repeat (3) begin @(posedge clk); #2; end
      check("sw_mem_before_rst", MemWrite, 1'b1);
      rst = 1'b1;
      #2;
      check("rst_mem_memwrite", MemWrite, 1'b0);
      @(posedge clk); #2;
      rst = 1'b0;
      #2;
      check("rst_mem_next_memwrite", MemWrite, 1'b0);
      check("rst_mem_loadPC", loadPC, 1'b0);

      run_instr(I_ADD, 1'b0, 1'b0, rw, mr, mw, alu, src, m2r);
      check("post_rst_regwrite", rw, 5'b10000);
      #2;
      check("post_rst_loadPC", loadPC, 1'b1);
      check("post_rst_instret", instret, 32'd1);
      check("post_rst_illegal", illegal, 1'b0);

      @(posedge clk); #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
